// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the 1:4 demux sequencer.
package demux_seq_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } seq_state_t;

  // Returns {found, lane}: the lowest set bit of word at or above index from.
  function automatic logic [LANE_W:0] next_set_lane(input logic [LANES-1:0] word,
                                                    input logic [LANE_W:0]  from);
    next_set_lane = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (word[i] && (i >= int'(from))) begin
        next_set_lane = {1'b1, LANE_W'(i)};
      end
    end
  endfunction

endpackage

// File: rtl/demux_lane_pick.sv
// Combinational next-set-bit finder; used by demux_seq_driver when SKIP_ZERO_EN is defined.
module demux_lane_pick
  import demux_seq_pkg::*;
(
  input  logic [LANES-1:0]  word_i,
  input  logic [LANE_W:0]   from_i,
  output logic              found_o,
  output logic [LANE_W-1:0] lane_o
);

  always_comb begin
    {found_o, lane_o} = next_set_lane(word_i, from_i);
  end

endmodule

// File: rtl/demux_seq_driver.sv
// Serialises a 4-bit lane word onto the 1:4 demux I/S pins, DWELL cycles per lane.
// Optional macro SKIP_ZERO_EN: lanes whose word bit is 0 are skipped.
module demux_seq_driver
  import demux_seq_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = $clog2(DWELL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             I,
  output logic [LANE_W-1:0] S,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DWELL - 1);

  seq_state_t        state_q, state_d;
  logic [LANES-1:0]  word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_q, i_d;
  logic [LANE_W-1:0] s_q, s_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              first_found, step_found;
  logic [LANE_W-1:0] first_lane, step_lane;

  assign din_ready = ((state_q == IDLE) || (state_q == DONE)) && !flush;
  assign accept    = din_valid && din_ready;

`ifdef SKIP_ZERO_EN
  demux_lane_pick u_pick_first (
    .word_i  (din),
    .from_i  ('0),
    .found_o (first_found),
    .lane_o  (first_lane)
  );

  demux_lane_pick u_pick_step (
    .word_i  (word_q),
    .from_i  ({1'b0, lane_q} + 3'd1),
    .found_o (step_found),
    .lane_o  (step_lane)
  );
`else
  assign first_found = 1'b1;
  assign first_lane  = '0;
  assign step_found  = (lane_q != LANE_W'(LANES - 1));
  assign step_lane   = lane_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      word_d  = din;
      cnt_d   = '0;
      lane_d  = first_lane;
      // An all-zero word with skipping enabled has nothing to drive.
      state_d = first_found ? DRIVE : DONE;
    end else begin
      case (state_q)
        DRIVE: begin
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (step_found) begin
              lane_d = step_lane;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from the next state so I/S follow an accept by one cycle.
  always_comb begin
    i_d    = 1'b0;
    s_d    = s_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      DRIVE: begin
        i_d    = word_d[lane_d];
        s_d    = lane_d;
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      i_q     <= 1'b0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign I          = i_q;
  assign S          = s_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_seq_driver.sv
// Bench for demux_seq_driver at DWELL=4/1/2 against a frame-schedule model (honours SKIP_ZERO_EN).
module tb_demux_seq_driver;

`ifdef SKIP_ZERO_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  typedef struct packed {
    logic       i;
    logic [1:0] s;
    logic       busy;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'b0000;
  logic       din_valid = 1'b0;
  logic       flush = 1'b0;

  logic [2:0] rdy, i_o, busy, fd;
  logic [1:0] s [3];
  logic [3:0] y0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The combinational 1:4 demux fed by instance 0.
  assign y0 = i_o[0] ? (4'b0001 << s[0]) : 4'b0000;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 2);

    demux_seq_driver #(.DWELL(D)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (rdy[g]),
      .flush      (flush),
      .I          (i_o[g]),
      .S          (s[g]),
      .busy       (busy[g]),
      .frame_done (fd[g])
    );

    // Model: an accepted word becomes a schedule of per-cycle outputs that is
    // then played back one entry per clock.
    exp_t       cur = '0;
    exp_t       sched[$];
    exp_t       e;
    logic [1:0] last;

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur = '0;
        sched.delete();
      end else if (flush) begin
        sched.delete();
        cur = {1'b0, cur.s, 2'b00};
      end else if (din_valid && !cur.busy) begin
        sched.delete();
        last = cur.s;
        for (int l = 0; l < 4; l++) begin
          if (din[l] || !Skip) begin
            for (int k = 0; k < D; k++) begin
              e = {din[l], 2'(l), 2'b10};
              sched.push_back(e);
            end
            last = 2'(l);
          end
        end
        e = {1'b0, last, 2'b01};
        sched.push_back(e);
        cur = sched.pop_front();
      end else if (sched.size() != 0) begin
        cur = sched.pop_front();
      end else begin
        cur = {1'b0, cur.s, 2'b00};
      end
    end

    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        check($sformatf("g%0d_I", g), int'(i_o[g]), int'(cur.i));
        check($sformatf("g%0d_S", g), int'(s[g]), int'(cur.s));
        check($sformatf("g%0d_busy", g), int'(busy[g]), int'(cur.busy));
        check($sformatf("g%0d_frame_done", g), int'(fd[g]), int'(cur.fd));
        check($sformatf("g%0d_din_ready", g), int'(rdy[g]), int'(!cur.busy && !flush));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word for one edge; returns in cycle 1 of the frame.
  task automatic accept(input logic [3:0] w);
    din       = w;
    din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
  endtask

  task automatic pin0(input string tag, input logic [3:0] y, input logic b, input logic f);
    check({tag, "_Y"}, int'(y0), int'(y));
    check({tag, "_busy"}, int'(busy[0]), int'(b));
    check({tag, "_frame_done"}, int'(fd[0]), int'(f));
  endtask

  initial begin
    logic [3:0] exp_i;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("reset_ready", int'(rdy[0]), 1);
    check("reset_S", int'(s[0]), 0);
    pin0("reset", 4'b0000, 1'b0, 1'b0);

    // Reset asserted mid-frame takes effect without a clock edge.
    accept(4'b1011);
    tick(2);
    rst_n = 1'b0;
    #1;
    pin0("async_rst", 4'b0000, 1'b0, 1'b0);
    check("async_rst_S", int'(s[0]), 0);
    check("async_rst_busy_all", int'(busy), 0);
    #2;
    rst_n = 1'b1;
    tick(1);
    check("rst_release_ready", int'(rdy[0]), 1);

    // DWELL=4 frame of 1011.
    accept(4'b1011);
    pin0("f_c1", 4'b0001, 1'b1, 1'b0);
    tick(3);  pin0("f_c4", 4'b0001, 1'b1, 1'b0);
    tick(1);  pin0("f_c5", 4'b0010, 1'b1, 1'b0);
    tick(3);  pin0("f_c8", 4'b0010, 1'b1, 1'b0);
    tick(1);  pin0("f_c9", 4'b0000, 1'b1, 1'b0);
    check("f_c9_S", int'(s[0]), 2);
    tick(3);  pin0("f_c12", 4'b0000, 1'b1, 1'b0);
    tick(1);  pin0("f_c13", 4'b1000, 1'b1, 1'b0);
    tick(3);  pin0("f_c16", 4'b1000, 1'b1, 1'b0);
    tick(1);  pin0("f_c17", 4'b0000, 1'b0, 1'b1);
    check("f_c17_S", int'(s[0]), 3);
    tick(10);

    // Back-to-back: second word taken in the DONE cycle.
    din       = 4'b1111;
    din_valid = 1'b1;
    tick(1);
    din = 4'b0101;
    tick(15); check("b2b_c16_S", int'(s[0]), 3);
    tick(1);  pin0("b2b_c17", 4'b0000, 1'b0, 1'b1);
    check("b2b_c17_ready", int'(rdy[0]), 1);
    tick(1);  pin0("b2b_c18", 4'b0001, 1'b1, 1'b0);
    check("b2b_c18_S", int'(s[0]), 0);
    din_valid = 1'b0;
    tick(25);

    // Flush in cycle 6 of a frame.
    accept(4'b1011);
    tick(5);
    flush = 1'b1;
    #1;
    check("flush_ready_low", int'(rdy[0]), 0);
    tick(1);
    flush = 1'b0;
    #1;
    pin0("flush_c7", 4'b0000, 1'b0, 1'b0);
    check("flush_c7_S", int'(s[0]), 1);
    check("flush_c7_ready", int'(rdy[0]), 1);
    tick(20);

    // DWELL=1 instance: one lane per cycle.
    exp_i = 4'b0110;
    accept(4'b0110);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("dw1_c%0d_S", c + 1), int'(s[1]), c);
      check($sformatf("dw1_c%0d_I", c + 1), int'(i_o[1]), int'(exp_i[c]));
      tick(1);
    end
    check("dw1_c5_frame_done", int'(fd[1]), 1);
    tick(20);

    // DWELL=2 instance, word 1001 then the all-zero word.
    accept(4'b1001);
    check("dw2_c1_S", int'(s[2]), 0);
    tick(2);
    check("dw2_c3_S", int'(s[2]), Skip ? 3 : 1);
    check("dw2_c3_I", int'(i_o[2]), Skip ? 1 : 0);
    tick(2);
    check("dw2_c5_frame_done", int'(fd[2]), Skip ? 1 : 0);
    tick(20);
    accept(4'b0000);
    check("dw2_zero_c1_frame_done", int'(fd[2]), Skip ? 1 : 0);
    check("dw2_zero_c1_busy", int'(busy[2]), Skip ? 0 : 1);
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
